// File: rtl/rv_plic_claim_seq.sv
// Claims PLIC interrupts over TL-UL, hands the ID to a hardware consumer,
// and completes the interrupt once the consumer reports done.
module rv_plic_claim_seq #(
  parameter int          NumSrc        = 55,
  parameter int          IdW           = 6,
  parameter logic [31:0] PlicBase      = 32'h0,
  parameter logic [8:0]  CcOffset      = 9'h10c,
  parameter int          HoldoffCycles = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           irq_i,
  input  logic           enable_i,
  output logic           tl_a_valid_o,
  input  logic           tl_a_ready_i,
  output logic [2:0]     tl_a_opcode_o,
  output logic [31:0]    tl_a_address_o,
  output logic [31:0]    tl_a_data_o,
  output logic [3:0]     tl_a_mask_o,
  input  logic           tl_d_valid_i,
  output logic           tl_d_ready_o,
  input  logic [31:0]    tl_d_data_i,
  input  logic           tl_d_error_i,
  output logic           id_valid_o,
  output logic [IdW-1:0] id_o,
  input  logic           id_ready_i,
  input  logic           done_i,
  output logic           busy_o,
  output logic           err_o,
  input  logic           err_clr_i,
  output logic [7:0]     spurious_cnt_o
);

  localparam logic [2:0]  OpGet     = 3'd4;
  localparam logic [2:0]  OpPutFull = 3'd0;
  localparam logic [31:0] CcAddr    = PlicBase + 32'(CcOffset);
  localparam logic [IdW:0] NumSrcW  = (IdW+1)'(NumSrc);
  localparam int          HoldW     = (HoldoffCycles > 1) ? $clog2(HoldoffCycles) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HoldoffCycles - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLAIM_REQ,
    S_CLAIM_RSP,
    S_DISPATCH,
    S_SERVICE,
    S_CMPL_REQ,
    S_CMPL_RSP,
    S_HOLDOFF
  } state_e;

  state_e           state_q, state_d;
  logic [IdW-1:0]   id_q, id_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             err_q, err_set;
  logic [7:0]       spur_q;
  logic             spur_inc;
  logic             busy_q;

  logic [IdW-1:0] rsp_id;
  logic           rsp_in_range;
  // Only the low IdW bits of the claim response carry the ID.
  logic           unused_rsp_bits;

  assign rsp_id          = tl_d_data_i[IdW-1:0];
  assign rsp_in_range    = {1'b0, rsp_id} < NumSrcW;
  assign unused_rsp_bits = ^tl_d_data_i[31:IdW];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    id_d     = id_q;
    hold_d   = hold_q;
    err_set  = 1'b0;
    spur_inc = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (irq_i && enable_i) state_d = S_CLAIM_REQ;
      end
      S_CLAIM_REQ: begin
        if (tl_a_ready_i) state_d = S_CLAIM_RSP;
      end
      S_CLAIM_RSP: begin
        if (tl_d_valid_i) begin
          if (tl_d_error_i) begin
            err_set = 1'b1;
            state_d = S_IDLE;
          end else if (rsp_id == '0) begin
            spur_inc = 1'b1;
            state_d  = S_IDLE;
          end else begin
            id_d = rsp_id;
            if (rsp_in_range) begin
              state_d = S_DISPATCH;
            end else begin
              // A bogus ID was still claimed in the PLIC, so it must be completed.
              err_set = 1'b1;
              state_d = S_CMPL_REQ;
            end
          end
        end
      end
      S_DISPATCH: begin
        if (id_ready_i) state_d = S_SERVICE;
      end
      S_SERVICE: begin
        if (done_i) state_d = S_CMPL_REQ;
      end
      S_CMPL_REQ: begin
        if (tl_a_ready_i) state_d = S_CMPL_RSP;
      end
      S_CMPL_RSP: begin
        if (tl_d_valid_i) begin
          err_set = tl_d_error_i;
          hold_d  = '0;
          state_d = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (hold_q == HoldLast) state_d = S_IDLE;
        else                    hold_d  = hold_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      hold_q  <= '0;
      err_q   <= 1'b0;
      spur_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      id_q    <= id_d;
      hold_q  <= hold_d;
      busy_q  <= (state_d != S_IDLE);
      if (err_set)        err_q <= 1'b1;
      else if (err_clr_i) err_q <= 1'b0;
      if (spur_inc && (spur_q != 8'hFF)) spur_q <= spur_q + 8'd1;
    end
  end

  assign tl_a_valid_o   = (state_q == S_CLAIM_REQ) || (state_q == S_CMPL_REQ);
  assign tl_a_opcode_o  = (state_q == S_CLAIM_REQ) ? OpGet : OpPutFull;
  assign tl_a_address_o = tl_a_valid_o ? CcAddr : 32'h0;
  assign tl_a_mask_o    = tl_a_valid_o ? 4'hF : 4'h0;
  assign tl_a_data_o    = (state_q == S_CMPL_REQ) ? 32'(id_q) : 32'h0;
  assign tl_d_ready_o   = (state_q == S_CLAIM_RSP) || (state_q == S_CMPL_RSP);
  assign id_valid_o     = (state_q == S_DISPATCH);
  assign id_o           = id_q;
  assign busy_o         = busy_q;
  assign err_o          = err_q;
  assign spurious_cnt_o = spur_q;

endmodule

// File: tb/tb_rv_plic_claim_seq.sv
// Randomized bench for rv_plic_claim_seq: the bench plays TL-UL slave and
// consumer, and checks each transaction against a transaction-level model.
module tb_rv_plic_claim_seq;

  localparam int NSRC = 55;
  localparam int HOLD = 2;
  localparam logic [31:0] CC_ADDR = 32'h0000_010c;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        irq = 1'b0, en = 1'b0;
  logic        a_valid, a_ready = 1'b0;
  logic [2:0]  a_opcode;
  logic [31:0] a_address, a_data;
  logic [3:0]  a_mask;
  logic        d_valid = 1'b0, d_ready;
  logic [31:0] d_data = '0;
  logic        d_error = 1'b0;
  logic        id_valid, id_ready = 1'b0;
  logic [5:0]  id;
  logic        done = 1'b0, busy, err, err_clr = 1'b0;
  logic [7:0]  spur;

  int n_vec = 0;
  int n_fail = 0;
  bit exp_err = 1'b0;
  int exp_spur = 0;

  always #5 clk = ~clk;

  rv_plic_claim_seq dut (
    .clk_i(clk), .rst_ni(rst_ni), .irq_i(irq), .enable_i(en),
    .tl_a_valid_o(a_valid), .tl_a_ready_i(a_ready), .tl_a_opcode_o(a_opcode),
    .tl_a_address_o(a_address), .tl_a_data_o(a_data), .tl_a_mask_o(a_mask),
    .tl_d_valid_i(d_valid), .tl_d_ready_o(d_ready), .tl_d_data_i(d_data),
    .tl_d_error_i(d_error), .id_valid_o(id_valid), .id_o(id),
    .id_ready_i(id_ready), .done_i(done), .busy_o(busy), .err_o(err),
    .err_clr_i(err_clr), .spurious_cnt_o(spur)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [2:0] op, input logic [31:0] data);
    check({tag, "_avalid"}, 32'(a_valid), 32'd1);
    check({tag, "_opcode"}, 32'(a_opcode), 32'(op));
    check({tag, "_addr"}, a_address, CC_ADDR);
    check({tag, "_mask"}, 32'(a_mask), 32'hF);
    check({tag, "_data"}, a_data, data);
  endtask

  // A-channel request with `stall` cycles of backpressure; fields re-checked each stalled cycle.
  task automatic a_phase(input string tag, input logic [2:0] op, input logic [31:0] data,
                         input int stall);
    check_a(tag, op, data);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_a({tag, "_held"}, op, data);
    end
    a_ready = 1'b1;
    @(negedge clk);
    a_ready = 1'b0;
    check({tag, "_a_done"}, 32'(a_valid), 32'd0);
    check({tag, "_dready"}, 32'(d_ready), 32'd1);
  endtask

  task automatic d_phase(input logic [31:0] data, input bit derr, input int delay);
    for (int i = 0; i < delay; i++) @(negedge clk);
    d_valid = 1'b1;
    d_data  = data;
    d_error = derr;
    @(negedge clk);
    d_valid = 1'b0;
    d_data  = '0;
    d_error = 1'b0;
  endtask

  // One full claim as seen from the bus; called from IDLE at a negedge.
  task automatic txn(input logic [31:0] rsp, input bit rerr, input bit cerr, input int ast,
                     input int dd, input int ist, input int dn, input bit early, input bit drop);
    logic [5:0] rid;
    rid = rsp[5:0];
    irq = 1'b1;
    en  = 1'b1;
    @(negedge clk);
    a_phase("claim", 3'd4, 32'h0, ast);
    irq = 1'b0;
    d_phase(rsp, rerr, dd);
    if (rerr) begin
      exp_err = 1'b1;
      check("claim_err_idle", 32'(busy), 32'd0);
      check("claim_err_flag", 32'(err), 32'(exp_err));
      check("claim_err_no_disp", 32'(id_valid), 32'd0);
      return;
    end
    if (rid == 6'd0) begin
      exp_spur = (exp_spur >= 255) ? 255 : exp_spur + 1;
      check("spur_idle", 32'(busy), 32'd0);
      check("spur_no_write", 32'(a_valid), 32'd0);
      check("spur_cnt", 32'(spur), 32'(exp_spur));
      return;
    end
    if (int'(rid) >= NSRC) begin
      exp_err = 1'b1;
      check("range_err", 32'(err), 32'd1);
      check("range_no_disp", 32'(id_valid), 32'd0);
    end else begin
      check("disp_valid", 32'(id_valid), 32'd1);
      check("disp_id", 32'(id), 32'(rid));
      for (int i = 0; i < ist; i++) begin
        if (early && i == 0) done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("disp_held_valid", 32'(id_valid), 32'd1);
        check("disp_held_id", 32'(id), 32'(rid));
        check("disp_no_write", 32'(a_valid), 32'd0);
      end
      id_ready = 1'b1;
      @(negedge clk);
      id_ready = 1'b0;
      check("disp_taken", 32'(id_valid), 32'd0);
      check("svc_no_write", 32'(a_valid), 32'd0);
      if (drop) en = 1'b0;
      for (int i = 0; i < dn; i++) begin
        @(negedge clk);
        check("svc_wait", 32'(a_valid), 32'd0);
      end
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
    end
    a_phase("cmpl", 3'd0, {26'd0, rid}, ast);
    d_phase($urandom, cerr, dd);
    if (cerr) exp_err = 1'b1;
    irq = 1'b1;  // must not be sampled during holdoff
    for (int i = 0; i < HOLD; i++) begin
      check("hold_busy", 32'(busy), 32'd1);
      check("hold_no_claim", 32'(a_valid), 32'd0);
      @(negedge clk);
    end
    irq = 1'b0;
    check("hold_end_idle", 32'(busy), 32'd0);
    check("cmpl_err", 32'(err), 32'(exp_err));
    check("cmpl_spur", 32'(spur), 32'(exp_spur));
    en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rsp;
    int sel;
    bit rerr;

    #12;
    check("rst_avalid", 32'(a_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_id", 32'(id), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_spur", 32'(spur), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);

    // Basic claim/dispatch/complete with ID 7.
    txn(32'h0000_0007, 0, 0, 0, 2, 0, 4, 0, 0);

    // Enable low: no bus traffic despite a pending interrupt.
    irq = 1'b1;
    en  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("disabled_no_claim", 32'(a_valid), 32'd0);
    end
    irq = 1'b0;
    en  = 1'b1;
    @(negedge clk);

    // Backpressure on A and dispatch, with an early done during DISPATCH.
    txn(32'h0000_0015, 0, 0, 4, 1, 3, 2, 1, 0);
    // Enable dropped during SERVICE still completes.
    txn(32'h0000_0021, 0, 0, 1, 0, 0, 3, 0, 1);
    // Claim bus error, then out-of-range ID 60, then clear.
    txn(32'hDEAD_0005, 1, 0, 0, 1, 0, 0, 0, 0);
    txn(32'd60, 0, 0, 0, 0, 0, 0, 0, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err = 1'b0;
    check("err_cleared", 32'(err), 32'd0);
    // Set wins over a simultaneous clear.
    err_clr = 1'b1;
    txn(32'h0, 1, 0, 0, 0, 0, 0, 0, 0);
    err_clr = 1'b0;
    @(negedge clk);
    check("err_set_priority", 32'(err), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err = 1'b0;

    // Randomized mix of transactions.
    for (int n = 0; n < 60; n++) begin
      sel  = $urandom_range(0, 9);
      rerr = (sel == 2);
      rsp  = $urandom & ~32'h3F;
      if (sel == 0)      rsp = rsp;
      else if (sel == 1) rsp = rsp | 32'($urandom_range(NSRC, 63));
      else               rsp = rsp | 32'($urandom_range(1, NSRC - 1));
      txn(rsp, rerr, ($urandom_range(0, 9) == 0), $urandom_range(0, 4), $urandom_range(0, 3),
          $urandom_range(1, 3), $urandom_range(0, 5), $urandom_range(0, 1),
          ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 7) == 0) begin
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_err = 1'b0;
        check("rand_err_clr", 32'(err), 32'd0);
      end
    end

    // Spurious counter saturation.
    for (int n = 0; n < 300; n++) txn(32'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("spur_saturated", 32'(spur), 32'd255);

    // Reset asserted during CMPL_REQ.
    irq = 1'b1;
    @(negedge clk);
    a_ready = 1'b1;
    @(negedge clk);
    a_ready = 1'b0;
    irq = 1'b0;
    d_phase(32'd9, 0, 0);
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("pre_rst_cmpl", 32'(a_valid), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst_avalid", 32'(a_valid), 32'd0);
    check("mid_rst_data", a_data, 32'd0);
    check("mid_rst_addr", a_address, 32'd0);
    check("mid_rst_mask", 32'(a_mask), 32'd0);
    check("mid_rst_dready", 32'(d_ready), 32'd0);
    check("mid_rst_idvalid", 32'(id_valid), 32'd0);
    check("mid_rst_id", 32'(id), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_spur", 32'(spur), 32'd0);
    exp_err  = 1'b0;
    exp_spur = 0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    txn(32'h0000_0033, 0, 0, 0, 1, 1, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_plic_claim_seq.md
# rv_plic_claim_seq

Hardware interrupt dispatcher sitting between one `rv_plic` target and a non-CPU interrupt consumer (DMA engine, mailbox or hardware handler). On `irq_o` from the PLIC it claims the interrupt by issuing a TL-UL Get to the target's CC register, presents the claimed ID on a valid/ready port, waits for the consumer's done pulse, then completes by writing the ID back to CC. It is the only bus host allowed to touch that target's CC register.

## Interface
- `NumSrc`, 55, PLIC source count; IDs `1..NumSrc-1` valid, ID 0 means "nothing pending".
- `IdW`, 6, ID width, `$clog2(NumSrc)`.
- `PlicBase`, 32'h0, PLIC base address.
- `CcOffset`, 9'h10c, offset of CC0.
- `HoldoffCycles`, 2, idle cycles after completion before `irq_i` is sampled again (≥1).

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `irq_i` in 1: PLIC target `irq_o`.
- `enable_i` in 1: permits new claims.
- `tl_a_valid_o` out 1, `tl_a_ready_i` in 1: A-channel handshake.
- `tl_a_opcode_o` out 3: 3'd4 Get, 3'd0 PutFullData.
- `tl_a_address_o` out 32, `tl_a_data_o` out 32, `tl_a_mask_o` out 4.
- `tl_d_valid_i` in 1, `tl_d_ready_o` out 1: D-channel handshake.
- `tl_d_data_i` in 32, `tl_d_error_i` in 1: response data/error.
- `id_valid_o` out 1, `id_o` out IdW, `id_ready_i` in 1: dispatch handshake.
- `done_i` in 1: one-cycle pulse, consumer finished servicing the dispatched ID.
- `busy_o` out 1: FSM not in IDLE.
- `err_o` out 1: sticky bus/ID error. `err_clr_i` in 1: clears `err_o`.
- `spurious_cnt_o` out 8: saturating count of claims returning ID 0.

## Operation
- FSM states: IDLE, CLAIM_REQ, CLAIM_RSP, DISPATCH, SERVICE, CMPL_REQ, CMPL_RSP, HOLDOFF.
- IDLE: `irq_i & enable_i` → CLAIM_REQ.
- CLAIM_REQ: `tl_a_valid_o`=1, Get, address `PlicBase + CcOffset`, mask 4'hF, data 0. On `tl_a_valid_o & tl_a_ready_i` → CLAIM_RSP.
- CLAIM_RSP: `tl_d_ready_o`=1. On `tl_d_valid_i`, capture `id = tl_d_data_i[IdW-1:0]`:
  - `tl_d_error_i` → set `err_o`, → IDLE.
  - id==0 → `spurious_cnt_o` += 1 (saturates at 255), → IDLE.
  - id≥NumSrc → set `err_o`, skip dispatch, → CMPL_REQ (must still complete).
  - else → DISPATCH.
- DISPATCH: `id_valid_o`=1, `id_o`=id, stable until `id_ready_i`; then → SERVICE.
- SERVICE: wait for `done_i` → CMPL_REQ. `done_i` in any other state is ignored.
- CMPL_REQ: PutFullData, same address, mask 4'hF, data = zero-extended id. On A handshake → CMPL_RSP.
- CMPL_RSP: `tl_d_ready_o`=1; on `tl_d_valid_i` → HOLDOFF; `tl_d_error_i` sets `err_o`.
- HOLDOFF: count `HoldoffCycles`, then → IDLE, which lets the PLIC's `irq_o` settle after completion.
- `enable_i` only gates IDLE→CLAIM_REQ. Deasserting it mid-sequence does not abort.
- `err_o`: set has priority over `err_clr_i` in the same cycle.
- At most one TL transaction outstanding. A-channel fields are held stable while `tl_a_valid_o & !tl_a_ready_i`.

## Timing
- Reset: state IDLE. All outputs 0, `id_o`=0, `spurious_cnt_o`=0, `err_o`=0.
- A reset assertion mid-sequence returns to IDLE asynchronously. Outstanding bus responses are not tracked.
- `irq_i` sampled high in IDLE → `tl_a_valid_o` high the next cycle.
- A handshake in cycle N → `tl_d_ready_o` high from cycle N+1.
- D handshake in cycle N → `id_valid_o` high in N+1 (non-spurious, in-range ID).
- `id_ready_i` in cycle N → SERVICE from N+1. `done_i` in cycle M → CMPL_REQ `tl_a_valid_o` in M+1.
- Completion D handshake in cycle K → IDLE at K+1+HoldoffCycles. The earliest new claim has A-valid at K+2+HoldoffCycles.
- `tl_d_valid_i` with a same-cycle A handshake cannot occur, because at most one transaction is outstanding.
- `busy_o` is a registered decode of state != IDLE.

## Test plan
- Basic: `irq_i`=1, `enable_i`=1. Slave returns 32'h0000_0007 after 2 cycles, `id_ready_i` immediate, `done_i` 5 cycles later → Get at 0x10c, then `id_o`=7, then PutFullData 0x10c with data 7 and mask F, then 2 HOLDOFF cycles, then IDLE.
- Spurious: claim returns 0 → no dispatch, no write, `spurious_cnt_o`=1. After 300 spurious claims → `spurious_cnt_o` saturates at 255.
- Backpressure: `tl_a_ready_i` low 4 cycles and `id_ready_i` low 3 cycles → A fields and `id_o` stay constant. An early `done_i` during DISPATCH is ignored and produces no completion write.
- Errors: `tl_d_error_i` on claim → `err_o`=1, back to IDLE. Claim returns 60 → `err_o`=1 and a completion write with data 60 follows, without dispatch. `err_clr_i` → `err_o`=0.
- `enable_i`=0 with `irq_i`=1 → no A traffic. `enable_i` dropped during SERVICE → completion still issued.
- Reset: assert `rst_ni` during CMPL_REQ → all outputs 0 immediately. After release with `irq_i`=1 → a fresh claim starts.
